serial_adder_seq: RTL
=====================

# serial_adder_seq

Bit-serial adder sequencer: accepts two WIDTH-bit operands and a carry-in, then steps a single one-bit FULL_ADDER cell over the operands LSB-first, one bit per clock. The result is presented with a one-cycle done pulse. It sits in the ARITHMETIC group as the area-minimal alternative to a ripple adder. It is the first block in that group that sequences a gate-level datapath over time.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; result valid.
- sum  output  WIDTH  registered result; held until the next accepted start completes.
- cout  output  1  registered carry-out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1: capture a, b and cin into shift registers, clear bit counter, go to RUN. With start=0: stay in IDLE.
- RUN, each cycle:
  - FULL_ADDER inputs are a_sh[0], b_sh[0] and carry register.
  - Shift a_sh and b_sh right by 1.
  - Shift the sum bit into the MSB of the accumulator.
  - Carry register takes the full-adder carry.
  - Counter increments.
- RUN exit: after WIDTH cycles (counter == WIDTH-1 on the current cycle), copy accumulator to sum and carry to cout, go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1: behave as IDLE accept and go to RUN (back-to-back).
  - start=0: go to IDLE.
- start in RUN is ignored; no queuing, no error flag.
- Arithmetic is modulo 2^WIDTH: {cout, sum} = a + b + cin, unsigned.
- Bit counter width is $clog2(WIDTH).
- Reset values: state IDLE; busy 0, done 0, sum 0, cout 0, ovf 0; all internal registers 0.
- Reset asserted mid-RUN aborts the operation. No done is issued and sum/cout return to 0.

## Timing
- Accepting edge E0.
- busy=1 in cycles E0+1 .. E0+WIDTH.
- done=1 and the new sum/cout are visible in cycle E0+WIDTH+1.
- Latency from start to done is WIDTH+1 cycles.
- Back-to-back throughput is one result per WIDTH+1 cycles.
- sum/cout do not change during RUN; they update only on the RUN→DONE edge.
- busy and done are never high together.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds output ovf = carry into MSB XOR carry out of MSB.
  - ovf is registered alongside cout and held with sum.
  - Requires one extra flop capturing the carry on the bit WIDTH-2 step.
- SERIAL_ADDER_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a WIDTH_MAX=32 constant used for the parameter range check.
- One sub-module: FULL_ADDER.
  - Combinational; ports in0, in1, in2, sum, carry.
  - Built from the existing gate primitives; instantiated once.
- Sequencer, shift registers, counter and result registers live in serial_adder_seq.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse → busy high 8 cycles; done at E0+9; sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; ovf=0 when enabled.
- a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0; ovf=1 when SERIAL_ADDER_OVF_EN is defined.
- start held high through RUN with different a/b → ignored; result from the first operands; second operation begins from DONE.
- Assert rst_n=0 at E0+4 → busy, done, sum and cout go to 0 immediately. No done follows. Next start completes normally.
- Back-to-back: start asserted in the DONE cycle with a=0x01, b=0x01 → done again at 9 cycles later; sum=0x02.

Source files
------------

// File: rtl/serial_adder_seq_pkg.sv
// Shared arithmetic-group package: sequencer state encoding and width limits.
package arith_pkg;

  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_seq_if.sv
// Operand/result bundle for serial_adder_seq.
// Optional macro SERIAL_ADDER_OVF_EN adds the ovf (signed overflow) signal.
interface serial_adder_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_seq_full_adder.sv
// One-bit full adder cell built from gate primitives.
module FULL_ADDER (
  input  logic in0,
  input  logic in1,
  input  logic in2,
  output logic sum,
  output logic carry
);
  logic w_x;
  logic w_g;
  logic w_p;

  xor u_x0 (w_x, in0, in1);
  xor u_x1 (sum, w_x, in2);
  and u_a0 (w_g, in0, in1);
  and u_a1 (w_p, w_x, in2);
  or  u_o0 (carry, w_g, w_p);
endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: one FULL_ADDER stepped LSB-first, one bit per
// clock, result registered with a single-cycle done pulse.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module serial_adder_seq
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder_seq: WIDTH out of range 2..WIDTH_MAX");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  // Holds only the upper WIDTH-1 result bits; the final sum bit is merged
  // in combinationally on the last step, so no dead LSB flop exists.
  logic [WIDTH-2:0]   r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_fa_sum;
  logic               w_fa_carry;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic               w_last;
  logic               w_accept;
  logic               w_busy;
  logic               w_done;

  FULL_ADDER u_fa (
    .in0   (r_a_sh[0]),
    .in1   (r_b_sh[0]),
    .in2   (r_carry),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  assign w_acc_nxt = {w_fa_sum, r_acc};
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept  = bus.start && ((r_state == IDLE) || (r_state == DONE));

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = bus.start ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit stepping and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_acc   <= '0;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_acc   <= w_acc_nxt[WIDTH-1:1];
      r_carry <= w_fa_carry;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_fa_carry;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_c_msb;
  logic r_ovf;

  // Carry into the MSB is captured on the WIDTH-2 step; overflow is its XOR
  // with the carry out of the MSB, registered with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == RUN && !w_accept) begin
      if (r_cnt == CNT_W'(WIDTH - 2)) r_c_msb <= w_fa_carry;
      if (w_last)                     r_ovf   <= r_c_msb ^ w_fa_carry;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
